// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered A/B decode stage with handshake, flag-hazard stall, redirect squash; DECODE_ILLEGAL_TRAP_EN adds an illegal-opcode trap
module decode_stage_pipe #(
  parameter int INSTR_W  = 16,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int BR_OFF_W = 7,
  parameter int FLAG_LAT = 1,
  parameter int SQUASH_N = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] iInstr,
  input  logic               iInstrValid,
  output logic               oInstrReady,
  input  logic [5:0]         iFlags,
  output logic               oValid,
  input  logic               iReady,
  output logic [5:0]         oOpcode,
  output logic [DATA_W-1:0]  oImm,
  output logic               oMuxASel,
  output logic               oMuxBSel,
  output logic               oFlagWrA,
  output logic               oFlagWrB,
  output logic               oRedirect,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic [ADDR_W-1:0]  oRedirectAddr,
  output logic               oIllegal
`else
  output logic [ADDR_W-1:0]  oRedirectAddr
`endif
);
  localparam logic [5:0] LDA   = 6'd0,  LDB   = 6'd1,  STA   = 6'd2,  STB   = 6'd3;
  localparam logic [5:0] ADDA  = 6'd4,  ADDB  = 6'd5,  SUBA  = 6'd6,  SUBB  = 6'd7;
  localparam logic [5:0] ANDA  = 6'd8,  ANDB  = 6'd9,  ORA   = 6'd10, ORB   = 6'd11;
  localparam logic [5:0] ASLA  = 6'd12, ASLB  = 6'd13, ASRA  = 6'd14, ASRB  = 6'd15;
  localparam logic [5:0] LDCA  = 6'd16, LDCB  = 6'd17, ADDCA = 6'd18, ADDCB = 6'd19;
  localparam logic [5:0] SUBCA = 6'd20, SUBCB = 6'd21, ANDCA = 6'd22, ANDCB = 6'd23;
  localparam logic [5:0] ORCA  = 6'd24, ORCB  = 6'd25;
  localparam logic [5:0] BAEQ  = 6'd26, BANE  = 6'd27, BACS  = 6'd28, BACC  = 6'd29;
  localparam logic [5:0] BAMI  = 6'd30, BAPL  = 6'd31;
  localparam logic [5:0] BBEQ  = 6'd32, BBNE  = 6'd33, BBCS  = 6'd34, BBCC  = 6'd35;
  localparam logic [5:0] BBMI  = 6'd36, BBPL  = 6'd37, JMP   = 6'd38;
  logic [5:0]        opc;
  logic              dMuxA, dMuxB, dFwA, dFwB, dBrA, dBrB, dJmp, dTaken, dTrap, dRedir;
  logic [DATA_W-1:0] dImm;
  logic [ADDR_W-1:0] dAddr;
  logic [2:0]        rPendA, rPendB;
  logic [1:0]        rSquash;
  logic              squashing, stall, accept, emit;
  assign opc = iInstr[INSTR_W-1 -: 6];
  always_comb begin
    dMuxA  = 1'b0;
    dMuxB  = 1'b0;
    dFwA   = 1'b0;
    dFwB   = 1'b0;
    dBrA   = 1'b0;
    dBrB   = 1'b0;
    dJmp   = 1'b0;
    dTaken = 1'b0;
    dTrap  = 1'b0;
    case (opc)
      LDA, ADDA, SUBA, ANDA, ORA, ASLA, ASRA: dFwA = 1'b1;
      LDB, ADDB, SUBB, ANDB, ORB, ASLB, ASRB: dFwB = 1'b1;
      STA, STB: ;
      LDCA: {dMuxA, dFwA} = 2'b11;
      LDCB: {dMuxB, dFwB} = 2'b11;
      ADDCA, SUBCA, ANDCA, ORCA: {dMuxB, dFwA} = 2'b11;
      ADDCB, SUBCB, ANDCB, ORCB: {dMuxA, dFwB} = 2'b11;
      BAEQ: {dBrA, dTaken} = {1'b1,  iFlags[0]};
      BANE: {dBrA, dTaken} = {1'b1, ~iFlags[0]};
      BACS: {dBrA, dTaken} = {1'b1,  iFlags[1]};
      BACC: {dBrA, dTaken} = {1'b1, ~iFlags[1]};
      BAMI: {dBrA, dTaken} = {1'b1,  iFlags[2]};
      BAPL: {dBrA, dTaken} = {1'b1, ~iFlags[2]};
      BBEQ: {dBrB, dTaken} = {1'b1,  iFlags[3]};
      BBNE: {dBrB, dTaken} = {1'b1, ~iFlags[3]};
      BBCS: {dBrB, dTaken} = {1'b1,  iFlags[4]};
      BBCC: {dBrB, dTaken} = {1'b1, ~iFlags[4]};
      BBMI: {dBrB, dTaken} = {1'b1,  iFlags[5]};
      BBPL: {dBrB, dTaken} = {1'b1, ~iFlags[5]};
      JMP:  dJmp = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
      default: dTrap = 1'b1;
`else
      default: ;
`endif
    endcase
  end
  assign dImm   = (dMuxA | dMuxB) ? iInstr[DATA_W-1:0] : '0;
  assign dRedir = dJmp | dTaken | dTrap;
  assign dAddr  = dTrap ? '1 : dJmp ? iInstr[ADDR_W-1:0] :
                  dTaken ? {{(ADDR_W-BR_OFF_W){1'b0}}, iInstr[BR_OFF_W-1:0]} : '0;
  assign squashing   = rSquash != 2'd0;
  // squashed instructions never wait on flags
  assign stall       = iInstrValid && !squashing && ((dBrA && rPendA != 3'd0) || (dBrB && rPendB != 3'd0));
  assign oInstrReady = !Reset && (!oValid || iReady) && !stall;
  assign accept      = iInstrValid && oInstrReady;
  assign emit        = accept && !squashing;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oValid        <= 1'b0;
      oOpcode       <= '0;
      oImm          <= '0;
      oMuxASel      <= 1'b0;
      oMuxBSel      <= 1'b0;
      oFlagWrA      <= 1'b0;
      oFlagWrB      <= 1'b0;
      oRedirect     <= 1'b0;
      oRedirectAddr <= '0;
      rPendA        <= '0;
      rPendB        <= '0;
      rSquash       <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      oIllegal      <= 1'b0;
`endif
    end else begin
      if (emit) begin
        oValid        <= 1'b1;
        oOpcode       <= opc;
        oImm          <= dImm;
        oMuxASel      <= dMuxA;
        oMuxBSel      <= dMuxB;
        oFlagWrA      <= dFwA;
        oFlagWrB      <= dFwB;
        oRedirect     <= dRedir;
        oRedirectAddr <= dAddr;
      end else if (iReady) oValid <= 1'b0;
      rPendA  <= (emit && dFwA) ? 3'(FLAG_LAT) : rPendA - {2'b0, rPendA != 3'd0};
      rPendB  <= (emit && dFwB) ? 3'(FLAG_LAT) : rPendB - {2'b0, rPendB != 3'd0};
      rSquash <= (emit && dRedir) ? 2'(SQUASH_N) : (accept && squashing) ? rSquash - 2'd1 : rSquash;
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (emit && dTrap) oIllegal <= 1'b1;
`endif
    end
  end
endmodule
